// File: rtl/seq_sub64_pkg.sv
// Shared definitions for the sequential slice-serial subtractor: default widths and FSM encodings.
package seq_sub64_pkg;
  localparam int         DEF_DATA_W  = 64;
  localparam int         DEF_CHUNK_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/seq_sub64_sub_chunk.sv
// Combinational W-bit slice adder with carry in/out; one instance is reused for every chunk.
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
endmodule

// File: rtl/seq_sub64.sv
// Slice-serial a - b (a + ~b + 1), one CHUNK_W slice per clock LSB first, with Y86 flags.
// Add mode (a + b + cin) is enabled by defining SEQ_SUB_ADD_MODE_EN.
module seq_sub64
  import seq_sub64_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
`ifdef SEQ_SUB_ADD_MODE_EN
  input  logic              op,
  input  logic              cin,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] diff,
  output logic              cout,
  output logic              zf,
  output logic              sf,
  output logic              of
);
  localparam int N_CHUNK = DATA_W / CHUNK_W;
  localparam int CNT_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
  localparam int MSB     = DATA_W - 1;

  if (DATA_W % CHUNK_W != 0) begin : g_bad_chunk
    $error("seq_sub64: DATA_W must be a multiple of CHUNK_W");
  end

  logic [1:0]        state;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] y_r;     // second operand as fed to the adder (~b or b)
  logic [DATA_W-1:0] diff_r;
  logic [CNT_W-1:0]  cnt;
  logic              carry;
  logic              cout_r, zf_r, sf_r, of_r;

  logic [CHUNK_W-1:0] a_ch, y_ch, s_ch;
  logic               co_ch;
  logic [DATA_W-1:0]  diff_nxt;
  logic               last;
  logic [DATA_W-1:0]  y_in;
  logic               c_in;

`ifdef SEQ_SUB_ADD_MODE_EN
  assign y_in = op ? ~b : b;
  assign c_in = op ? 1'b1 : cin;
`else
  assign y_in = ~b;
  assign c_in = 1'b1;
`endif

  always_comb begin
    a_ch     = a_r[cnt*CHUNK_W +: CHUNK_W];
    y_ch     = y_r[cnt*CHUNK_W +: CHUNK_W];
    diff_nxt = diff_r;
    diff_nxt[cnt*CHUNK_W +: CHUNK_W] = s_ch;
  end

  assign last = (cnt == CNT_W'(N_CHUNK - 1));

  sub_chunk #(.W(CHUNK_W)) u_chunk (
    .x  (a_ch),
    .y  (y_ch),
    .ci (carry),
    .s  (s_ch),
    .co (co_ch)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_r    <= '0;
      y_r    <= '0;
      diff_r <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      zf_r   <= 1'b0;
      sf_r   <= 1'b0;
      of_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            a_r   <= a;
            y_r   <= y_in;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          diff_r <= diff_nxt;
          carry  <= co_ch;
          if (last) begin
            state  <= ST_DONE;
            cnt    <= '0;
            cout_r <= co_ch;
            zf_r   <= (diff_nxt == '0);
            sf_r   <= diff_nxt[MSB];
            // Same form for add and subtract because y_r already holds ~b when subtracting.
            of_r   <= (a_r[MSB] == y_r[MSB]) && (diff_nxt[MSB] != a_r[MSB]);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign diff = diff_r;
  assign cout = cout_r;
  assign zf   = zf_r;
  assign sf   = sf_r;
  assign of   = of_r;
endmodule

// File: tb/tb_seq_sub64.sv
// Directed bench for seq_sub64: hand-computed vectors, latency, start-while-busy and mid-run reset.
module tb_seq_sub64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        busy, done, cout, zf, sf, of;
  logic [63:0] diff;
`ifdef SEQ_SUB_ADD_MODE_EN
  logic        op = 1'b1;
  logic        cin = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  always #5 clk = ~clk;

  seq_sub64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SEQ_SUB_ADD_MODE_EN
    .op    (op),
    .cin   (cin),
`endif
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .cout  (cout),
    .zf    (zf),
    .sf    (sf),
    .of    (of)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands before an edge and hold start for exactly that accepting edge.
  task automatic launch(input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges until done is seen (sampled mid-cycle); -1 if it never comes.
  task automatic wait_done(input int already, output int edges);
    edges = -1;
    for (int i = already + 1; i <= already + 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic sub_case(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] ed, input logic ec, input logic ez,
                          input logic es, input logic eo);
    launch(av, bv);
    wait_done(0, cyc);
    check({tag, "_lat"},  64'(cyc), 64'd8);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
    check({tag, "_zf"},   {63'd0, zf},   {63'd0, ez});
    check({tag, "_sf"},   {63'd0, sf},   {63'd0, es});
    check({tag, "_of"},   {63'd0, of},   {63'd0, eo});
    @(negedge clk);
    check({tag, "_pulse"}, {62'd0, busy, done}, 64'd0);
    check({tag, "_hold"},  diff, ed);
  endtask

  initial begin
    int saw_done;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_diff", diff, 64'd0);
    check("rst_flags", {60'd0, cout, zf, sf, of}, 64'd0);
    rst_n = 1'b1;

    sub_case("s25m10", 64'd25, 64'd10, 64'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    sub_case("s10m10", 64'd10, 64'd10, 64'd0,  1'b1, 1'b1, 1'b0, 1'b0);
    sub_case("s0m1",   64'd0,  64'd1,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    sub_case("smin",   64'h8000_0000_0000_0000, 64'd1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);

    // start and operand changes during RUN must not disturb the running op.
    launch(64'd100, 64'd58);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ign_busy", {63'd0, busy}, 64'd1);
    start = 1'b1;
    a = 64'd7;
    b = 64'd1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4, cyc);
    check("ign_lat",  64'(cyc), 64'd8);
    check("ign_diff", diff, 64'd42);
    check("ign_cout", {63'd0, cout}, 64'd1);
    @(negedge clk);
    check("ign_idle", {63'd0, busy}, 64'd0);

    // Reset in the middle of a run: everything back to zero and no done afterwards.
    launch(64'd25, 64'd10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_done", {63'd0, done}, 64'd0);
    check("mrst_diff", diff, 64'd0);
    check("mrst_flags", {60'd0, cout, zf, sf, of}, 64'd0);
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    check("mrst_nodone", 64'(saw_done), 64'd0);

`ifdef SEQ_SUB_ADD_MODE_EN
    op = 1'b0;
    cin = 1'b1;
    launch(64'd10, 64'd15);
    wait_done(0, cyc);
    check("add_lat",  64'(cyc), 64'd8);
    check("add_diff", diff, 64'd26);
    check("add_cout", {63'd0, cout}, 64'd0);
    cin = 1'b0;
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_done(0, cyc);
    check("addw_diff", diff, 64'd0);
    check("addw_cout", {63'd0, cout}, 64'd1);
    check("addw_zf",   {63'd0, zf}, 64'd1);
    check("addw_of",   {63'd0, of}, 64'd0);
    op = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
